// File: rtl/uart_defs_pkg.sv
// rtl/uart_defs_pkg.sv - shared UART framing constants, state encoding and divider helper
package uart_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    // Clocks per bit; shared with the receiver so both sides agree on timing.
    function automatic int calc_clk_div(input int clock, input int baud_rate);
        return clock / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period divider emitting a one-cycle tick every CLK_DIV clocks
module uart_baud_tick #(
    parameter int CLK_DIV = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..CLK_DIV-1 while enabled; parked at zero when disabled or cleared.
    always_ff @(posedge CLK) begin
        if (RST || CLR || !EN) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign TICK = EN && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with one-byte holding register
module uart_tx
    import uart_defs::*;
#(
    parameter int CLOCK     = 1_000_000,
    parameter int BAUD_RATE = 9_600
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] D,
    input  logic       WR,
    output logic       TX,
    output logic       TXE,
    output logic       BUSY
);

    localparam int CLK_DIV = calc_clk_div(CLOCK, BAUD_RATE);

    generate
        if (CLK_DIV < 2) begin : g_bad_div
            $error("uart_tx: CLOCK/BAUD_RATE must be at least 2");
        end
    endgenerate

    uart_state_t                 state, state_n;
    logic [FRAME_BITS-1:0]       shift, shift_n;
    logic [2:0]                  bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0]        hold, hold_n;
    logic                        hold_full, hold_full_n;
    logic                        tx_q, tx_n;
    logic                        busy_q, busy_n;
    logic                        load;
    logic                        tick;

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (state != ST_IDLE),
        .CLR  (load),
        .TICK (tick)
    );

    // Register all transmitter state; reset aborts any frame and drops the held byte.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            shift     <= '1;
            bit_cnt   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            bit_cnt   <= bit_cnt_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            tx_q      <= tx_n;
            busy_q    <= busy_n;
        end
    end

    // Frame sequencing: start, eight data bits LSB first, stop, then chain or idle.
    always_comb begin
        state_n     = state;
        shift_n     = shift;
        bit_cnt_n   = bit_cnt;
        hold_n      = hold;
        hold_full_n = hold_full;
        tx_n        = tx_q;
        busy_n      = busy_q;
        load        = 1'b0;

        case (state)
            ST_IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (hold_full) begin
                    load    = 1'b1;
                    state_n = ST_START;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    shift_n   = shift >> 1;
                    tx_n      = shift[1];
                    bit_cnt_n = '0;
                    state_n   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_n = shift >> 1;
                    tx_n    = shift[1];
                    if (bit_cnt == 3'd7) begin
                        state_n = ST_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (hold_full) begin
                        load    = 1'b1;
                        state_n = ST_START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = ST_IDLE;
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase

        // Moving the held byte into the shifter frees the holding register.
        if (load) begin
            shift_n     = {1'b1, hold, 1'b0};
            hold_full_n = 1'b0;
        end

        // A load needs a full holding register, so it never coincides with an accepted write.
        if (WR && !hold_full) begin
            hold_n      = D;
            hold_full_n = 1'b1;
        end
    end

    assign TX   = tx_q;
    assign TXE  = !hold_full;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx with CLK_DIV=16
module tb_uart_tx;

    logic       CLK;
    logic       RST;
    logic [7:0] D;
    logic       WR;
    logic       TX;
    logic       TXE;
    logic       BUSY;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx #(
        .CLOCK     (16),
        .BAUD_RATE (1)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .D    (D),
        .WR   (WR),
        .TX   (TX),
        .TXE  (TXE),
        .BUSY (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge just after the start-bit load edge; returns 160 cycles later.
    task automatic check_frame(input string tag, input logic [7:0] b);
        logic [9:0] fr;
        logic [7:0] got;
        int         bad;
        fr  = {1'b1, b, 1'b0};
        got = 8'h00;
        bad = 0;
        for (int k = 0; k < 160; k++) begin
            if (TX !== fr[k / 16] || BUSY !== 1'b1) bad++;
            if ((k % 16) == 8 && k >= 16 && k < 144) got[(k / 16) - 1] = TX;
            @(negedge CLK);
        end
        chk({tag, "_shape"}, bad, 0);
        chk({tag, "_byte"}, {24'h0, got}, {24'h0, b});
    endtask

    // Counts cycles where the line is not idle, over n cycles.
    task automatic check_idle(input string tag, input int n);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            if (TX !== 1'b1 || TXE !== 1'b1 || BUSY !== 1'b0) bad++;
            @(negedge CLK);
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        RST = 1'b1;
        WR  = 1'b0;
        D   = 8'h00;
        repeat (3) @(negedge CLK);
        chk("reset_tx", {31'h0, TX}, 32'h1);
        chk("reset_txe", {31'h0, TXE}, 32'h1);
        chk("reset_busy", {31'h0, BUSY}, 32'h0);
        RST = 1'b0;

        check_idle("idle_100", 100);

        // Single frame 0x55
        D  = 8'h55;
        WR = 1'b1;
        @(negedge CLK);
        WR = 1'b0;
        chk("wr_txe_low", {31'h0, TXE}, 32'h0);
        chk("wr_tx_still_idle", {31'h0, TX}, 32'h1);
        chk("wr_busy_still_low", {31'h0, BUSY}, 32'h0);
        @(negedge CLK);
        chk("load_txe_high", {31'h0, TXE}, 32'h1);
        check_frame("f55", 8'h55);
        chk("f55_end_busy", {31'h0, BUSY}, 32'h0);
        chk("f55_end_tx", {31'h0, TX}, 32'h1);
        check_idle("idle_after_55", 20);

        // Back-to-back 0xA3 then 0x0F, with 0xFF offered while full
        D  = 8'hA3;
        WR = 1'b1;
        @(negedge CLK);
        D = 8'h0F;
        @(negedge CLK);
        fork
            check_frame("fA3", 8'hA3);
            begin
                @(negedge CLK);
                chk("queued_txe_low", {31'h0, TXE}, 32'h0);
                D = 8'hFF;
                repeat (5) @(negedge CLK);
                chk("full_txe_low", {31'h0, TXE}, 32'h0);
                WR = 1'b0;
            end
        join
        check_frame("f0F", 8'h0F);
        chk("pair_end_busy", {31'h0, BUSY}, 32'h0);
        check_idle("no_third_frame", 200);

        // Reset mid-frame, with a write on the reset edge
        D  = 8'h00;
        WR = 1'b1;
        @(negedge CLK);
        WR = 1'b0;
        @(negedge CLK);
        repeat (49) @(negedge CLK);
        chk("mid_frame_tx", {31'h0, TX}, 32'h0);
        chk("mid_frame_busy", {31'h0, BUSY}, 32'h1);
        RST = 1'b1;
        WR  = 1'b1;
        D   = 8'h5A;
        @(negedge CLK);
        RST = 1'b0;
        WR  = 1'b0;
        chk("abort_tx", {31'h0, TX}, 32'h1);
        chk("abort_busy", {31'h0, BUSY}, 32'h0);
        chk("abort_txe", {31'h0, TXE}, 32'h1);
        check_idle("idle_after_abort", 200);

        // Clean frame after abort
        D  = 8'h81;
        WR = 1'b1;
        @(negedge CLK);
        WR = 1'b0;
        @(negedge CLK);
        check_frame("f81", 8'h81);
        check_idle("idle_after_81", 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
